fp_std_pipe: RTL and testbench

Parametrised successor of the single-source FP standardise stage. It accepts unnormalised results from two producers: source A (CORDIC) and source B (FP add). Sources are arbitrated round-robin under valid/ready, and each result is normalised, rounded round-to-nearest-even to a configurable sign/exponent/mantissa format, and emitted with backpressure. It sits between the FP execution units and the register/predicate write-back. It also produces predicate results for SEQ/SLT and handles the override and CVTFR paths.

---
 rtl/fp_std_pkg.sv | 8 +
 rtl/opcode_pkg.sv | 9 +
 rtl/fp_lzc.sv | 19 +
 rtl/fp_std_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_fp_std_pipe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_std_pkg.sv
// Shared types and helpers for the FP standardise pipeline.
package fp_std_pkg;
    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction
endpackage

// File: rtl/opcode_pkg.sv
// Execution-unit opcode encodings shared by the FP pipeline blocks.
package opcode_pkg;
    typedef logic [4:0] func5_t;

    localparam func5_t FADD  = 5'h00;
    localparam func5_t SEQ   = 5'h10;
    localparam func5_t SLT   = 5'h11;
    localparam func5_t CVTFR = 5'h14;
endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter with an all-zero flag.
module fp_lzc #(
    parameter int W = 18,
    localparam int CW = $clog2(W)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          zero
);
    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

    assign zero = ~|value;
endmodule

// File: rtl/fp_std_pipe.sv
// Two-source FP standardise pipeline: round-robin arbitration, normalise, RNE round, predicates.
// Optional exception flag outputs are enabled by defining FP_STD_EXC_FLAGS_EN.
module fp_std_pipe
    import opcode_pkg::*;
    import fp_std_pkg::*;
#(
    parameter int EXP_W    = 7,
    parameter int MAN_W    = 10,
    parameter int IN_MAN_W = 18,
    parameter int TAG_W    = 5,
    localparam int FMT_W   = 1 + EXP_W + MAN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  func5_t              a_func5,
    input  logic                a_sign,
    input  logic [EXP_W-1:0]    a_exp,
    input  logic [IN_MAN_W-1:0] a_man,
    input  logic                a_override,
    input  logic [FMT_W-1:0]    a_override_val,
    input  logic [TAG_W-1:0]    a_tag,
    input  logic                b_valid,
    output logic                b_ready,
    input  func5_t              b_func5,
    input  logic                b_sign,
    input  logic [EXP_W-1:0]    b_exp,
    input  logic [IN_MAN_W-1:0] b_man,
    input  logic [TAG_W-1:0]    b_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FMT_W-1:0]    out_res,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_set_pred,
`ifdef FP_STD_EXC_FLAGS_EN
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_inexact,
`endif
    output logic                out_pred_val
);
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(IN_MAN_W);
    localparam int EMAX = 2 * fp_bias(EXP_W) + 1;

    typedef struct packed {
        func5_t                  func5;
        logic                    sign;
        logic signed [EW-1:0]    e;
        logic [MAN_W-1:0]        frac;
        logic                    guard;
        logic                    sticky;
        logic                    zero;
        logic                    override;
        logic [FMT_W-1:0]        override_val;
        logic [TAG_W-1:0]        tag;
    } std_stage_t;

    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    function automatic logic [FMT_W-1:0] saturate(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic adv0, adv1, adv2;
    logic grant_a, grant_b, accept;
    src_t last_grant;

    assign adv2    = out_ready | ~vld_p2;
    assign adv1    = adv2 | ~vld_p1;
    assign adv0    = adv1 | ~vld_p0;
    assign grant_a = a_valid & (~b_valid | (last_grant == SRC_B));
    assign grant_b = b_valid & ~grant_a;
    assign a_ready = adv0 & grant_a;
    assign b_ready = adv0 & grant_b;
    assign accept  = a_ready | b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            last_grant <= SRC_B;
        end else begin
            if (adv0) vld_p0 <= accept;
            if (adv1) vld_p1 <= vld_p0;
            if (adv2) vld_p2 <= vld_p1;
            if (accept) last_grant <= grant_a ? SRC_A : SRC_B;
        end
    end

    // ---- S0: arbitration / input register ----
    func5_t                func5_p0;
    logic                  sign_p0;
    logic [EXP_W-1:0]      exp_p0;
    logic [IN_MAN_W-1:0]   man_p0;
    logic                  ovr_p0;
    logic [FMT_W-1:0]      ovr_val_p0;
    logic [TAG_W-1:0]      tag_p0;

    always_ff @(posedge clk) begin
        if (accept) begin
            if (grant_a) begin
                func5_p0   <= a_func5;
                sign_p0    <= a_sign;
                exp_p0     <= a_exp;
                man_p0     <= a_man;
                ovr_p0     <= a_override;
                ovr_val_p0 <= a_override_val;
                tag_p0     <= a_tag;
            end else begin
                func5_p0   <= b_func5;
                sign_p0    <= b_sign;
                exp_p0     <= b_exp;
                man_p0     <= b_man;
                ovr_p0     <= 1'b0;
                ovr_val_p0 <= '0;
                tag_p0     <= b_tag;
            end
        end
    end

    // ---- S1: normalise register ----
    logic [CW-1:0]        lz_cnt;
    logic                 man_zero;
    logic [IN_MAN_W-1:0]  shifted;
    logic [IN_MAN_W-1:0]  rest;
    logic signed [EW-1:0] norm_e;
    std_stage_t           stage_p1;

    fp_lzc #(.W(IN_MAN_W)) u_lzc (
        .value (man_p0),
        .count (lz_cnt),
        .zero  (man_zero)
    );

    // Leading one lands at the top bit, so exponent adjusts by 1 - lz_cnt.
    assign shifted = man_p0 << lz_cnt;
    assign rest    = shifted << (MAN_W + 2);
    assign norm_e  = {2'b00, exp_p0} + EW'(1) - EW'(lz_cnt);

    // CVTFR reuses the verbatim path with the raw top mantissa bits.
    always_ff @(posedge clk) begin
        if (adv1) begin
            stage_p1.func5        <= func5_p0;
            stage_p1.sign         <= sign_p0;
            stage_p1.e            <= norm_e;
            stage_p1.frac         <= shifted[IN_MAN_W-2 -: MAN_W];
            stage_p1.guard        <= shifted[IN_MAN_W-2-MAN_W];
            stage_p1.sticky       <= |rest;
            stage_p1.zero         <= man_zero;
            stage_p1.override     <= ovr_p0 | (func5_p0 == CVTFR);
            stage_p1.override_val <= ovr_p0 ? ovr_val_p0 : man_p0[IN_MAN_W-1 -: FMT_W];
            stage_p1.tag          <= tag_p0;
        end
    end

    // ---- S2: round register ----
    logic [MAN_W:0]       sum;
    logic signed [EW-1:0] e_fin;
    logic                 flush, sat;
    logic [FMT_W-1:0]     res_next;
    logic                 pred_op_next, pred_val_next;

    always_comb begin
        sum      = {1'b0, stage_p1.frac}
                 + (MAN_W+1)'(rne_inc(stage_p1.frac[0], stage_p1.guard, stage_p1.sticky));
        e_fin    = stage_p1.e + EW'(sum[MAN_W]);
        flush    = stage_p1.zero | e_fin[EW-1] | (e_fin == '0);
        sat      = ~flush & (e_fin >= EW'(EMAX));
        res_next = {stage_p1.sign, e_fin[EXP_W-1:0], sum[MAN_W-1:0]};
        if (stage_p1.override)  res_next = stage_p1.override_val;
        else if (flush)         res_next = {stage_p1.sign, {(FMT_W-1){1'b0}}};
        else if (sat)           res_next = saturate(stage_p1.sign);

        pred_op_next  = (stage_p1.func5 == SEQ) | (stage_p1.func5 == SLT);
        pred_val_next = 1'b0;
        if (stage_p1.func5 == SEQ)      pred_val_next = (res_next[FMT_W-2:0] == '0);
        else if (stage_p1.func5 == SLT) pred_val_next = res_next[FMT_W-1];
    end

    logic [FMT_W-1:0] res_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             pred_op_p2, pred_val_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p2      <= '0;
            tag_p2      <= '0;
            pred_op_p2  <= 1'b0;
            pred_val_p2 <= 1'b0;
        end else if (adv2) begin
            res_p2      <= res_next;
            tag_p2      <= stage_p1.tag;
            pred_op_p2  <= pred_op_next;
            pred_val_p2 <= pred_val_next;
        end
    end

`ifdef FP_STD_EXC_FLAGS_EN
    logic ovf_p2, unf_p2, inexact_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p2     <= 1'b0;
            unf_p2     <= 1'b0;
            inexact_p2 <= 1'b0;
        end else if (adv2) begin
            ovf_p2     <= ~stage_p1.override & sat;
            unf_p2     <= ~stage_p1.override & ~stage_p1.zero & flush;
            inexact_p2 <= ~stage_p1.override & (stage_p1.guard | stage_p1.sticky);
        end
    end

    assign out_ovf     = ovf_p2;
    assign out_unf     = unf_p2;
    assign out_inexact = inexact_p2;
`endif

    assign out_valid    = vld_p2;
    assign out_res      = res_p2;
    assign out_tag      = tag_p2;
    assign out_set_pred = vld_p2 & pred_op_p2;
    assign out_pred_val = pred_val_p2;
endmodule

// File: tb/tb_fp_std_pipe.sv
// Directed self-checking bench for fp_std_pipe (default parameters).
module tb_fp_std_pipe;
    import opcode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_sign, a_override;
    func5_t      a_func5;
    logic [6:0]  a_exp;
    logic [17:0] a_man, a_override_val;
    logic [4:0]  a_tag;
    logic        b_valid, b_ready, b_sign;
    func5_t      b_func5;
    logic [6:0]  b_exp;
    logic [17:0] b_man;
    logic [4:0]  b_tag;
    logic        out_valid, out_ready, out_set_pred, out_pred_val;
    logic [17:0] out_res;
    logic [4:0]  out_tag;
`ifdef FP_STD_EXC_FLAGS_EN
    logic        out_ovf, out_unf, out_inexact;
`endif

    int vectors = 0;
    int miscompares = 0;
    int sent, recv;

    always #5 clk = ~clk;

    fp_std_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_func5        (a_func5),
        .a_sign         (a_sign),
        .a_exp          (a_exp),
        .a_man          (a_man),
        .a_override     (a_override),
        .a_override_val (a_override_val),
        .a_tag          (a_tag),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_func5        (b_func5),
        .b_sign         (b_sign),
        .b_exp          (b_exp),
        .b_man          (b_man),
        .b_tag          (b_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_res        (out_res),
        .out_tag        (out_tag),
        .out_set_pred   (out_set_pred),
`ifdef FP_STD_EXC_FLAGS_EN
        .out_ovf        (out_ovf),
        .out_unf        (out_unf),
        .out_inexact    (out_inexact),
`endif
        .out_pred_val   (out_pred_val)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one result, check exact 3-cycle latency, then check the output word.
    task automatic xact(input string nm, input bit use_b, input func5_t f, input logic s,
                        input logic [6:0] e, input logic [17:0] m, input logic ov,
                        input logic [17:0] ovv, input logic [4:0] t,
                        input logic [17:0] x_res, input logic x_sp, input logic x_pv);
        step();
        if (use_b) begin
            b_valid = 1'b1; b_func5 = f; b_sign = s; b_exp = e; b_man = m; b_tag = t;
        end else begin
            a_valid = 1'b1; a_func5 = f; a_sign = s; a_exp = e; a_man = m;
            a_override = ov; a_override_val = ovv; a_tag = t;
        end
        #1;
        chk({nm, ".ready"}, use_b ? b_ready : a_ready, 1);
        step();
        a_valid = 1'b0; b_valid = 1'b0; a_override = 1'b0;
        chk({nm, ".lat1"}, out_valid, 0);
        step();
        chk({nm, ".lat2"}, out_valid, 0);
        step();
        chk({nm, ".valid"}, out_valid, 1);
        chk({nm, ".res"}, out_res, x_res);
        chk({nm, ".tag"}, out_tag, t);
        chk({nm, ".set_pred"}, out_set_pred, x_sp);
        chk({nm, ".pred_val"}, out_pred_val, x_pv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        a_valid = 1'b0; a_func5 = FADD; a_sign = 1'b0; a_exp = '0; a_man = '0;
        a_override = 1'b0; a_override_val = '0; a_tag = '0;
        b_valid = 1'b0; b_func5 = FADD; b_sign = 1'b0; b_exp = '0; b_man = '0; b_tag = '0;
        step(); step();
        chk("rst.valid", out_valid, 0);
        chk("rst.res", out_res, 0);
        chk("rst.tag", out_tag, 0);
        chk("rst.set_pred", out_set_pred, 0);
        chk("rst.pred_val", out_pred_val, 0);
        rst_n = 1'b1;

        xact("a_basic",  0, FADD, 0, 7'd63,  18'h10000, 0, 0, 5'h03, 18'h0FC00, 0, 0);
        xact("b_carry",  1, FADD, 0, 7'd63,  18'h20000, 0, 0, 5'h07, 18'h10000, 0, 0);
        xact("b_tie",    1, FADD, 0, 7'd63,  18'h10020, 0, 0, 5'h08, 18'h0FC00, 0, 0);
        xact("b_rndup",  1, FADD, 0, 7'd63,  18'h10060, 0, 0, 5'h09, 18'h0FC02, 0, 0);
        xact("b_rndcy",  1, FADD, 0, 7'd63,  18'h1FFE0, 0, 0, 5'h0A, 18'h10000, 0, 0);
        xact("a_sat",    0, FADD, 0, 7'd126, 18'h20000, 0, 0, 5'h0B, 18'h1FC00, 0, 0);
        xact("a_flush",  0, FADD, 0, 7'd1,   18'h08000, 0, 0, 5'h0C, 18'h00000, 0, 0);
        xact("a_seq0",   0, SEQ,  1, 7'd40,  18'h00000, 0, 0, 5'h0D, 18'h20000, 1, 1);
        xact("a_slt",    0, SLT,  1, 7'd63,  18'h10000, 0, 0, 5'h0E, 18'h2FC00, 1, 1);
        xact("a_cvtfr",  0, CVTFR,0, 7'd3,   18'h2ABCD, 0, 0, 5'h0F, 18'h2ABCD, 0, 0);
        xact("b_seq1",   1, SEQ,  0, 7'd63,  18'h10000, 0, 0, 5'h10, 18'h0FC00, 1, 0);
        xact("b_slt",    1, SLT,  0, 7'd63,  18'h10000, 0, 0, 5'h11, 18'h0FC00, 1, 0);

        // Last accept was B, so a collision must alternate A,B,A,B.
        step();
        a_valid = 1'b1; a_func5 = FADD; a_sign = 0; a_exp = 7'd63; a_man = 18'h10000; a_tag = 5'h0A;
        b_valid = 1'b1; b_func5 = FADD; b_sign = 0; b_exp = 7'd63; b_man = 18'h20000; b_tag = 5'h0B;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin a_valid = 1'b0; b_valid = 1'b0; end
            #1;
            if (i < 4) begin
                chk("arb.a_ready", a_ready, (i % 2 == 0));
                chk("arb.b_ready", b_ready, (i % 2 == 1));
            end
            if (i >= 3) begin
                chk("arb.valid", out_valid, 1);
                chk("arb.tag", out_tag, ((i - 3) % 2 == 0) ? 5'h0A : 5'h0B);
                chk("arb.res", out_res, ((i - 3) % 2 == 0) ? 18'h0FC00 : 18'h10000);
            end
            step();
        end
        chk("arb.drain", out_valid, 0);

        // Backpressure: six results, consumer stalls for cycles 4..8.
        sent = 0; recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            a_valid = (sent < 6); a_func5 = FADD; a_sign = 0;
            a_exp = 7'(10 + sent); a_man = 18'h10000; a_tag = 5'(sent);
            #1;
            if (!out_ready) chk("bp.ready_low", a_ready, 0);
            if (c >= 3) chk("bp.valid", out_valid, 1);
            if (out_valid) begin
                chk("bp.tag", out_tag, recv);
                chk("bp.res", out_res, {1'b0, 7'(10 + recv), 10'h000});
                if (out_ready) recv++;
            end
            if (a_valid && a_ready) sent++;
            step();
        end
        a_valid = 1'b0; out_ready = 1'b1;
        chk("bp.sent", sent, 6);
        chk("bp.recv", recv, 6);

        // Reset with three results in flight, then override after release.
        step();
        a_valid = 1'b1; a_func5 = FADD; a_exp = 7'd63; a_man = 18'h10000;
        for (int i = 0; i < 3; i++) begin
            a_tag = 5'(i + 1);
            #1;
            chk("rst2.accept", a_ready, 1);
            step();
        end
        a_valid = 1'b0;
        chk("rst2.pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2.valid", out_valid, 0);
        chk("rst2.res", out_res, 0);
        chk("rst2.tag", out_tag, 0);
        step();
        rst_n = 1'b1;
        xact("ovr",      0, FADD, 1, 7'd5, 18'h3FFFF, 1, 18'h35A5A, 5'h1F, 18'h35A5A, 0, 0);
        xact("ovr_seq",  0, SEQ,  0, 7'd5, 18'h3FFFF, 1, 18'h20000, 5'h12, 18'h20000, 1, 1);
        step();
        chk("end.idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
